// File: rtl/vga_pkg.sv
// Shared widths, pipeline tap record and generated glyph table for the
// VGA drawing chain.
package vga_pkg;

  localparam int HCNT_W    = 11;
  localparam int RGB_W     = 12;
  localparam int CHAR_W    = 8;
  localparam int FONT_ROWS = 16;
  localparam int FONT_COLS = 8;
  localparam int FONT_AW   = 11;  // {code[6:0], line[3:0]}

  // One VGA sample travelling down the overlay delay line.
  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [HCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [RGB_W-1:0]  rgb;
    logic              in_box;
  } vga_tap_t;

  // Generated font: code 0 (space) is blank; every other glyph lights its
  // leftmost column so any non-space cell is visible, and the remaining seven
  // pixels form a code/line dependent pattern.
  function automatic logic [FONT_COLS-1:0] glyph_row(input logic [6:0] code,
                                                     input logic [3:0] line);
    logic [FONT_COLS-1:0] row;
    row = '0;
    if (code != 7'h00) begin
      row = {1'b1, code ^ 7'h54 ^ {line, line[2:0]}};
    end
    return row;
  endfunction

endpackage

// File: rtl/font_rom.sv
// 8x16 font ROM, 128 glyphs, registered read (one clock latency).
module font_rom
  import vga_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FONT_AW-1:0]   addr,
  output logic [FONT_COLS-1:0] char_line_pixels
);

  localparam int DEPTH = 1 << FONT_AW;

  logic [FONT_COLS-1:0] w_rom [0:DEPTH-1];
  logic [FONT_COLS-1:0] r_pixels;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rom
      assign w_rom[gi] = glyph_row(7'(gi >> 4), 4'(gi));
    end
  endgenerate

  // Registered lookup of one glyph row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixels <= '0;
    end else begin
      r_pixels <= w_rom[addr];
    end
  end

  assign char_line_pixels = r_pixels;

endmodule

// File: rtl/draw_text_overlay.sv
// Text overlay stage: addresses the external text ROM from the pixel position,
// looks the returned code up in the font ROM and paints set glyph pixels.
// Four-clock latency on every timing signal.
module draw_text_overlay
  import vga_pkg::*;
#(
  parameter int               X_POS      = 400,
  parameter int               Y_POS      = 300,
  parameter int               COLS       = 14,
  parameter int               ROWS       = 2,
  parameter logic [RGB_W-1:0] TEXT_COLOR = 12'hfff
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HCNT_W-1:0] hcount_in,
  input  logic [HCNT_W-1:0] vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic [CHAR_W-1:0] char_code,
  output logic [CHAR_W-1:0] char_yx,
  output logic [HCNT_W-1:0] hcount_out,
  output logic [HCNT_W-1:0] vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  // Box bounds; right and bottom edges exclusive.
  localparam logic [HCNT_W-1:0] X_LO = HCNT_W'(X_POS);
  localparam logic [HCNT_W-1:0] X_HI = HCNT_W'(X_POS + FONT_COLS * COLS);
  localparam logic [HCNT_W-1:0] Y_LO = HCNT_W'(Y_POS);
  localparam logic [HCNT_W-1:0] Y_HI = HCNT_W'(Y_POS + FONT_ROWS * ROWS);
  // Stages before the output register: address, text ROM, font ROM.
  localparam int NSTG = 3;

  logic [HCNT_W-1:0] w_x_rel;
  logic [HCNT_W-1:0] w_y_rel;
  logic              w_in_box;
  vga_tap_t          w_tap_in [1:NSTG];
  vga_tap_t          r_tap    [1:NSTG];
  logic [2:0]        w_xbit_in [1:NSTG];
  logic [2:0]        r_xbit    [1:NSTG];
  logic [3:0]        r_line1;
  logic [3:0]        r_line2;
  logic [CHAR_W-1:0] r_char_yx;
  logic [FONT_AW-1:0]   w_font_addr;
  logic [FONT_COLS-1:0] w_font_row;
  logic              w_pix;
  logic              w_blank;
  vga_tap_t          w_out;
  vga_tap_t          r_out;
  logic              w_unused;

  // Box-relative position and membership of the incoming sample.
  always_comb begin
    w_x_rel  = hcount_in - X_LO;
    w_y_rel  = vcount_in - Y_LO;
    w_in_box = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
               (vcount_in >= Y_LO) && (vcount_in < Y_HI);
    w_tap_in[1]  = '{hcount: hcount_in, vcount: vcount_in,
                     hsync: hsync_in, vsync: vsync_in,
                     hblnk: hblnk_in, vblnk: vblnk_in,
                     rgb: rgb_in, in_box: w_in_box};
    w_xbit_in[1] = w_x_rel[2:0];
  end

  // Text ROM address and glyph line; outside the box the address is parked at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_char_yx <= '0;
      r_line1   <= '0;
      r_line2   <= '0;
    end else begin
      r_char_yx <= w_in_box ? {w_y_rel[7:4], w_x_rel[6:3]} : '0;
      r_line1   <= w_y_rel[3:0];
      r_line2   <= r_line1;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= NSTG; gi++) begin : g_dly
      if (gi > 1) begin : g_chain
        assign w_tap_in[gi]  = r_tap[gi-1];
        assign w_xbit_in[gi] = r_xbit[gi-1];
      end
      // One delay-line stage for timing, colour, box flag and pixel column.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tap[gi]  <= '0;
          r_xbit[gi] <= '0;
        end else begin
          r_tap[gi]  <= w_tap_in[gi];
          r_xbit[gi] <= w_xbit_in[gi];
        end
      end
    end
  endgenerate

  // char_code[7] is not part of the 7-bit font address.
  assign w_font_addr = {char_code[6:0], r_line2};

  font_rom u_font_rom (
    .clk              (clk),
    .rst              (rst),
    .addr             (w_font_addr),
    .char_line_pixels (w_font_row)
  );

  // Pick the glyph pixel (MSB is leftmost) and composite over upstream colour.
  always_comb begin
    w_pix   = w_font_row[3'd7 - r_xbit[NSTG]];
    w_blank = r_tap[NSTG].hblnk | r_tap[NSTG].vblnk;
    w_out   = r_tap[NSTG];
    w_out.in_box = 1'b0;
    if (w_blank) begin
      w_out.rgb = '0;
    end else if (r_tap[NSTG].in_box && w_pix) begin
      w_out.rgb = TEXT_COLOR;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_out;
    end
  end

  assign char_yx    = r_char_yx;
  assign hcount_out = r_out.hcount;
  assign vcount_out = r_out.vcount;
  assign hsync_out  = r_out.hsync;
  assign vsync_out  = r_out.vsync;
  assign hblnk_out  = r_out.hblnk;
  assign vblnk_out  = r_out.vblnk;
  assign rgb_out    = r_out.rgb;

  assign w_unused = ^{char_code[7], w_x_rel[HCNT_W-1:7], w_y_rel[HCNT_W-1:8], r_out.in_box};

endmodule
